// File: rtl/scroll_pkg.sv
// Shared types, widths and rotation arithmetic for the HELLO rotator scroll controller.
// The optional STEP debouncer is enabled with the SCROLL_STEP_DEBOUNCE_EN macro.
package scroll_pkg;

   localparam int ROT_W       = 3;
   localparam int NUM_POS_DEF = 8;

   typedef enum logic {
      PAUSED = 1'b0,
      SCROLL = 1'b1
   } state_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // One rotation step with wrap at both ends of the 0..num_pos-1 range.
   function automatic logic [ROT_W-1:0] rot_next(input logic [ROT_W-1:0] rot,
                                                 input logic             dir,
                                                 input int               num_pos);
      logic [ROT_W-1:0] v;
      if (dir == DIR_UP) begin
         v = (int'(rot) == num_pos - 1) ? '0 : rot + 1'b1;
      end else begin
         v = (rot == '0) ? ROT_W'(num_pos - 1) : rot - 1'b1;
      end
      return v;
   endfunction

   function automatic logic [ROT_W-1:0] load_wrap(input logic [ROT_W-1:0] v,
                                                  input int               num_pos);
      return ROT_W'(int'(v) % num_pos);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for RUN and STEP plus a rising-edge detector on STEP.
// With SCROLL_STEP_DEBOUNCE_EN defined, the synchronised STEP passes a debouncer first.
module sync_edge_det
   import scroll_pkg::*;
`ifdef SCROLL_STEP_DEBOUNCE_EN
#(
   parameter int DB_CYCLES = 1_000_000
)
`endif
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_run,
   input  logic i_step,
   output logic o_run_s,
   output logic o_step_edge
);

   // bit 1 = RUN, bit 0 = STEP
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic       r_lvl_d;
   logic       w_lvl;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {i_run, i_step};
         r_sync2 <= r_sync1;
      end
   end

`ifdef SCROLL_STEP_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic          r_db;
   logic [CW-1:0] r_db_cnt;

   // Output follows the input only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_db     <= 1'b0;
         r_db_cnt <= '0;
      end else if (r_sync2[0] != r_db) begin
         if (r_db_cnt == DB_LAST) begin
            r_db     <= r_sync2[0];
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end else begin
         r_db_cnt <= '0;
      end
   end

   assign w_lvl = r_db;
`else
   assign w_lvl = r_sync2[0];
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lvl_d <= 1'b0;
      end else begin
         r_lvl_d <= w_lvl;
      end
   end

   assign o_run_s     = r_sync2[1];
   assign o_step_edge = w_lvl & ~r_lvl_d;

endmodule

// File: rtl/scroll_ctrl.sv
// Rotation-select generator for the HELLO rotator: auto-scroll, manual step, direction, load.
// Optional STEP debouncing is selected with the SCROLL_STEP_DEBOUNCE_EN macro.
module scroll_ctrl
   import scroll_pkg::*;
#(
   parameter int CLK_DIV   = 50_000_000,
   parameter int NUM_POS   = NUM_POS_DEF,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic             CLOCK_50,
   input  logic             RESET,
   input  logic             RUN,
   input  logic             DIR,
   input  logic             STEP,
   input  logic             LOAD,
   input  logic [ROT_W-1:0] LOAD_VAL,
   output logic [ROT_W-1:0] ROT,
   output logic             TICK,
   output logic             STATE
);

   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRE_TC = PW'(CLK_DIV - 1);

   state_e           r_state;
   state_e           w_state_next;
   logic [PW-1:0]    r_pre;
   logic [PW-1:0]    w_pre_next;
   logic [ROT_W-1:0] r_rot;
   logic [ROT_W-1:0] w_rot_next;
   logic             r_tick;
   logic             w_run_s;
   logic             w_step_edge;
   logic             w_adv;

   sync_edge_det
`ifdef SCROLL_STEP_DEBOUNCE_EN
   #(
      .DB_CYCLES (DB_CYCLES)
   )
`endif
   u_sync (
      .i_clk       (CLOCK_50),
      .i_rst       (RESET),
      .i_run       (RUN),
      .i_step      (STEP),
      .o_run_s     (w_run_s),
      .o_step_edge (w_step_edge)
   );

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_state <= PAUSED;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         PAUSED:  if (w_run_s)  w_state_next = SCROLL;
         SCROLL:  if (!w_run_s) w_state_next = PAUSED;
         default: w_state_next = PAUSED;
      endcase
   end

   // LOAD wins over any advance; the prescaler only runs while SCROLL is held.
   always_comb begin
      w_adv      = 1'b0;
      w_pre_next = '0;
      w_rot_next = r_rot;
      if (r_state == SCROLL) begin
         w_adv = (r_pre == PRE_TC);
         if (w_run_s && !w_adv) begin
            w_pre_next = r_pre + 1'b1;
         end
      end else begin
         w_adv = w_step_edge;
      end
      if (w_adv) begin
         w_rot_next = rot_next(r_rot, DIR, NUM_POS);
      end
      if (LOAD) begin
         w_rot_next = load_wrap(LOAD_VAL, NUM_POS);
         w_pre_next = '0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_rot  <= '0;
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_rot  <= w_rot_next;
         r_pre  <= w_pre_next;
         r_tick <= w_adv | LOAD;
      end
   end

   assign ROT   = r_rot;
   assign TICK  = r_tick;
   assign STATE = (r_state == SCROLL);

endmodule

// File: tb/tb_scroll_ctrl.sv
// Randomised bench for scroll_ctrl against a cycle-indexed reference model of the rotator rules.
// Define SCROLL_STEP_DEBOUNCE_EN to also exercise the STEP debouncer.
module tb_scroll_ctrl;

  localparam int CLK_DIV = 4;
  localparam int NUM_POS = 8;
  localparam int DB      = 8;
  localparam int MAXC    = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       dir;
  logic       step;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] rot;
  logic       tick;
  logic       state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scroll_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .NUM_POS   (NUM_POS),
    .DB_CYCLES (DB)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .RUN      (run),
    .DIR      (dir),
    .STEP     (step),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .ROT      (rot),
    .TICK     (tick),
    .STATE    (state_o)
  );

  // reference model: input history indexed by clock edge number
  bit rec_run  [MAXC];
  bit rec_step [MAXC];
  bit lvl      [MAXC];
  int last_rst = -1;
  int cyc      = 0;
  int m_rot    = 0;
  int m_pre    = 0;
  bit m_scroll = 0;
  bit m_tick   = 0;
  int db_val   = 0;
  int db_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit samp(input int k, input bit is_run);
    if (k < 0 || k <= last_rst) return 1'b0;
    return is_run ? rec_run[k] : rec_step[k];
  endfunction

  function automatic bit lvl_at(input int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    return lvl[k];
  endfunction

  task automatic model_edge(input int n);
    bit rs;
    bit se;
    bit adv;
    rec_run[n]  = run;
    rec_step[n] = step;
    if (rst) begin
      last_rst = n;
      lvl[n]   = 1'b0;
      m_rot    = 0;
      m_pre    = 0;
      m_scroll = 0;
      m_tick   = 0;
      db_val   = 0;
      db_cnt   = 0;
    end else begin
      rs  = samp(n - 2, 1'b1);
      se  = lvl_at(n - 1) & ~lvl_at(n - 2);
      adv = 1'b0;
      if (load) begin
        m_rot = int'(load_val) % NUM_POS;
        m_pre = 0;
      end else begin
        if (m_scroll) begin
          if (m_pre == CLK_DIV - 1) begin
            adv   = 1'b1;
            m_pre = 0;
          end else begin
            m_pre++;
          end
        end else if (se) begin
          adv = 1'b1;
        end
        if (adv) m_rot = dir ? (m_rot + NUM_POS - 1) % NUM_POS : (m_rot + 1) % NUM_POS;
      end
      m_tick = adv | load;
      if (m_scroll && !rs) m_pre = 0;
      m_scroll = rs;
`ifdef SCROLL_STEP_DEBOUNCE_EN
      if (int'(samp(n - 2, 1'b0)) != db_val) begin
        db_cnt++;
        if (db_cnt == DB) begin
          db_val = 1 - db_val;
          db_cnt = 0;
        end
      end else begin
        db_cnt = 0;
      end
      lvl[n] = bit'(db_val);
`else
      lvl[n] = samp(n - 1, 1'b0);
`endif
    end
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic do_cycle();
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    @(negedge clk);
    check_eq("rot", rot, m_rot);
    check_eq("tick", tick, m_tick);
    check_eq("state", state_o, m_scroll);
  endtask

  initial begin
    int cnt;
    int changes;
    int k;
    int e0;
    int hit;
    logic [2:0] prev;

    rst = 1; run = 1; dir = 0; step = 1; load = 0; load_val = 0;

    // reset with RUN and STEP high
    do_cycle();
    do_cycle();
    check_eq("rst_rot", rot, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_state", state_o, 0);

    // auto-scroll up from 0
    rst = 0; step = 0;
    k = 0;
    while (!m_scroll && k < 10) begin
      do_cycle();
      k++;
    end
    check_eq("scroll_entry_edges", k, 3);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      do_cycle();
      cnt += int'(tick);
    end
    check_eq("tick_count_32", cnt, 8);
    check_eq("rot_after_lap", rot, 0);

    // scroll down across the wrap
    dir = 1;
    for (int i = 0; i < 10; i++) do_cycle();

    // manual: one step per press regardless of hold time
    run = 0; dir = 0;
    for (int i = 0; i < 6; i++) do_cycle();
    changes = 0;
    step = 1;
    for (int i = 0; i < 25; i++) begin
      if (i == 20) step = 0;
      prev = rot;
      do_cycle();
      if (rot != prev) changes++;
    end
    check_eq("step_once", changes, 1);

    // LOAD on a terminal-count cycle discards the advance
    run = 1;
    k = 0;
    while (!(m_scroll && m_pre == CLK_DIV - 1) && k < 40) begin
      do_cycle();
      k++;
    end
    check_eq("tc_reached", (m_scroll && m_pre == CLK_DIV - 1), 1);
    load = 1; load_val = 5;
    do_cycle();
    load = 0;
    check_eq("load_rot", rot, 5);
    check_eq("load_tick", tick, 1);
    k = 0;
    hit = 0;
    while (!hit && k < 10) begin
      do_cycle();
      k++;
      hit = int'(tick);
    end
    check_eq("load_gap", k, 4);
    check_eq("load_next_rot", rot, 6);

`ifdef SCROLL_STEP_DEBOUNCE_EN
    // bouncing STEP gives no step; a steady press gives one after the window
    run = 0; step = 0;
    for (int i = 0; i < 6; i++) do_cycle();
    changes = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) step = ~step;
      prev = rot;
      do_cycle();
      if (rot != prev) changes++;
    end
    step = 1;
    e0 = cyc;
    hit = -1;
    for (int i = 0; i < 20; i++) begin
      prev = rot;
      do_cycle();
      if (rot != prev) begin
        changes++;
        if (hit < 0) hit = cyc - e0;
      end
    end
    check_eq("db_one_step", changes, 1);
    check_eq("db_latency", hit, 3 + DB);
    step = 0;
    for (int i = 0; i < 20; i++) do_cycle();
`endif

    // random traffic including mid-run resets
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 3) == 0) step = ~step;
      load     = ($urandom_range(0, 19) == 0);
      load_val = 3'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 149) == 0);
      do_cycle();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
